// File: rtl/raifes_jtag_master.sv
// JTAG master: turns IR/DR scan and TAP-reset commands into TCK/TMS/TDI bit
// sequences with a fixed clock divider, and returns the captured TDO bits.
//
// state | meaning
// IDLE  | TAP parked in Run-Test/Idle, waiting for a command
// TLR   | six TMS bits 1,1,1,1,1,0: Test-Logic-Reset, then Run-Test/Idle
// HDR   | walk Run-Test/Idle -> Shift-IR (1,1,0,0) or Shift-DR (1,0,0)
// SHIFT | cmd_len data bits, TMS=1 on the last one (leaves via Exit1)
// TAIL  | TMS 1,0: Update then back to Run-Test/Idle
// RESP  | response held until rsp_ready
module raifes_jtag_master #(
  parameter int HALF_PERIOD = 2,
  parameter int MAX_LEN     = 41
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int PH_W  = (2*HALF_PERIOD > 2) ? $clog2(2*HALF_PERIOD) : 1;
  localparam int BIT_W = ($clog2(MAX_LEN) > 3) ? $clog2(MAX_LEN) : 3;

  localparam logic [PH_W-1:0] PH_HIGH = PH_W'(HALF_PERIOD);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2*HALF_PERIOD-1);

  typedef enum logic [2:0] {IDLE, TLR, HDR, SHIFT, TAIL, RESP} state_t;

  state_t             state, state_n;
  logic [PH_W-1:0]    ph, ph_n;
  logic [BIT_W-1:0]   bit_cnt, bit_n;
  logic               tlr_cmd, tlr_cmd_n;
  logic               is_ir, is_ir_n;
  logic [BIT_W-1:0]   len_last, len_last_n;
  logic [MAX_LEN-1:0] data_q, data_n;
  logic [MAX_LEN-1:0] cap, cap_n;

  logic               load;
  logic               cmd_bad;
  logic               last_bit;
  logic               running_n;

  logic               tck_n, tms_n, tdi_n, cmd_ready_n;
  logic               rsp_valid_n, rsp_err_n;
  logic [MAX_LEN-1:0] rsp_data_n;

  assign cmd_bad = (cmd_type == 2'd3) || (cmd_len == 6'd0) ||
                   ({26'd0, cmd_len} > 32'(MAX_LEN));

  always_comb begin
    case (state)
      TLR:     last_bit = (bit_cnt == BIT_W'(5));
      HDR:     last_bit = (bit_cnt == (is_ir ? BIT_W'(3) : BIT_W'(2)));
      SHIFT:   last_bit = (bit_cnt == len_last);
      TAIL:    last_bit = (bit_cnt == BIT_W'(1));
      default: last_bit = 1'b0;
    endcase
  end

  // Sequencer: state, divider phase, bit index and response registers.
  always_comb begin
    state_n     = state;
    ph_n        = ph;
    bit_n       = bit_cnt;
    tlr_cmd_n   = tlr_cmd;
    load        = 1'b0;
    cap_n       = cap;
    rsp_valid_n = rsp_valid;
    rsp_err_n   = rsp_err;
    rsp_data_n  = rsp_data;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          ph_n  = '0;
          bit_n = '0;
          if (cmd_bad) begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
            rsp_data_n  = '0;
          end else if (cmd_type == 2'd0) begin
            state_n   = TLR;
            tlr_cmd_n = 1'b1;
          end else begin
            state_n = HDR;
            load    = 1'b1;
            cap_n   = '0;
          end
        end
      end
      TLR, HDR, SHIFT, TAIL: begin
        if (state == SHIFT && ph == PH_HIGH)
          cap_n = cap | (MAX_LEN'(tdo) << bit_cnt);
        if (ph == PH_LAST) begin
          ph_n = '0;
          if (last_bit) begin
            bit_n = '0;
            case (state)
              TLR: begin
                tlr_cmd_n = 1'b0;
                if (tlr_cmd) begin
                  state_n     = RESP;
                  rsp_valid_n = 1'b1;
                  rsp_err_n   = 1'b0;
                  rsp_data_n  = '0;
                end else begin
                  state_n = IDLE;
                end
              end
              HDR:   state_n = SHIFT;
              SHIFT: state_n = TAIL;
              default: begin
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b0;
                rsp_data_n  = cap;
              end
            endcase
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end else begin
          ph_n = ph + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b0;
          rsp_err_n   = 1'b0;
          rsp_data_n  = '0;
        end
      end
      default: state_n = TLR;
    endcase
  end

  // Pin values are derived from the next bit position so that tck/tms/tdi
  // can be registered; tms/tdi are constant within a bit by construction.
  always_comb begin
    is_ir_n    = load ? (cmd_type == 2'd1) : is_ir;
    len_last_n = load ? BIT_W'(cmd_len - 6'd1) : len_last;
    data_n     = load ? cmd_data : data_q;
    running_n  = (state_n == TLR) || (state_n == HDR) ||
                 (state_n == SHIFT) || (state_n == TAIL);
    tck_n       = running_n && (ph_n >= PH_HIGH);
    tms_n       = 1'b0;
    tdi_n       = 1'b0;
    cmd_ready_n = (state_n == IDLE);
    case (state_n)
      TLR:   tms_n = (bit_n != BIT_W'(5));
      HDR:   tms_n = (bit_n < (is_ir_n ? BIT_W'(2) : BIT_W'(1)));
      SHIFT: begin
        tms_n = (bit_n == len_last_n);
        tdi_n = |(data_n & (MAX_LEN'(1) << bit_n));
      end
      TAIL:  tms_n = (bit_n == BIT_W'(0));
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TLR;
      ph        <= '0;
      bit_cnt   <= '0;
      tlr_cmd   <= 1'b0;
      is_ir     <= 1'b0;
      len_last  <= '0;
      data_q    <= '0;
      cap       <= '0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_n;
      ph        <= ph_n;
      bit_cnt   <= bit_n;
      tlr_cmd   <= tlr_cmd_n;
      is_ir     <= is_ir_n;
      len_last  <= len_last_n;
      data_q    <= data_n;
      cap       <= cap_n;
      tck       <= tck_n;
      tms       <= tms_n;
      tdi       <= tdi_n;
      cmd_ready <= cmd_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_data  <= rsp_data_n;
    end
  end

endmodule

// File: tb/tb_raifes_jtag_master.sv
// Bench for raifes_jtag_master driving a behavioural DTM-style TAP; responses
// are checked by a scoreboard monitor decoupled from the command driver.
module tb_raifes_jtag_master;

  localparam logic [40:0] DMI_CAP = {7'h05, 32'hCAFE_F00D, 2'b00};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = 2'd0;
  logic [5:0]  cmd_len = 6'd0;
  logic [40:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [40:0] rsp_data;
  logic        rsp_err;
  logic        tck, tms, tdi;
  logic        tdo = 1'b0;

  raifes_jtag_master #(.HALF_PERIOD(2), .MAX_LEN(41)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tck_cnt = 0;
  int acc_cyc = 0;
  int acc_tck = 0;
  int hold_viol = 0;
  int tms_viol = 0;
  logic [5:0] tms_hist = '0;

  typedef struct {
    string       name;
    logic        err;
    logic [40:0] data;
    int          lat;
    int          pulses;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;
  always @(posedge tck) begin
    tck_cnt++;
    tms_hist = {tms_hist[4:0], tms};
  end

  // Behavioural TAP: IR 5 bits (capture 00001), IDCODE 0x01, DMI 0x11, else bypass.
  typedef enum int {T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
                    T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR} tap_t;
  tap_t        tap_st = T_TLR;
  logic [4:0]  tap_ir = 5'h01;
  logic [4:0]  ir_sr = '0;
  logic [40:0] dr_sr = '0;
  int          dmi_wr_cnt = 0;
  logic [6:0]  dmi_addr = '0;
  logic [31:0] dmi_wdata = '0;

  always @(posedge tck) begin
    case (tap_st)
      T_TLR:  tap_ir = 5'h01;
      T_CDR:  dr_sr = (tap_ir == 5'h01) ? 41'h10001001 : (tap_ir == 5'h11) ? DMI_CAP : 41'h0;
      T_SHDR: begin
        if (tap_ir == 5'h01)      dr_sr = {9'b0, tdi, dr_sr[31:1]};
        else if (tap_ir == 5'h11) dr_sr = {tdi, dr_sr[40:1]};
        else                      dr_sr = {40'b0, tdi};
      end
      T_UDR: if (tap_ir == 5'h11 && dr_sr[1:0] == 2'b10) begin
        dmi_wr_cnt++;
        dmi_addr  = dr_sr[40:34];
        dmi_wdata = dr_sr[33:2];
      end
      T_CIR:  ir_sr = 5'h01;
      T_SHIR: ir_sr = {tdi, ir_sr[4:1]};
      T_UIR:  tap_ir = ir_sr;
      default: ;
    endcase
    case (tap_st)
      T_TLR:  tap_st = tms ? T_TLR  : T_RTI;
      T_RTI:  tap_st = tms ? T_SDR  : T_RTI;
      T_SDR:  tap_st = tms ? T_SIR  : T_CDR;
      T_CDR:  tap_st = tms ? T_E1DR : T_SHDR;
      T_SHDR: tap_st = tms ? T_E1DR : T_SHDR;
      T_E1DR: tap_st = tms ? T_UDR  : T_PDR;
      T_PDR:  tap_st = tms ? T_E2DR : T_PDR;
      T_E2DR: tap_st = tms ? T_UDR  : T_SHDR;
      T_UDR:  tap_st = tms ? T_SDR  : T_RTI;
      T_SIR:  tap_st = tms ? T_TLR  : T_CIR;
      T_CIR:  tap_st = tms ? T_E1IR : T_SHIR;
      T_SHIR: tap_st = tms ? T_E1IR : T_SHIR;
      T_E1IR: tap_st = tms ? T_UIR  : T_PIR;
      T_PIR:  tap_st = tms ? T_E2IR : T_PIR;
      T_E2IR: tap_st = tms ? T_UIR  : T_SHIR;
      default: tap_st = tms ? T_SDR  : T_RTI;
    endcase
  end

  always @(negedge tck)
    tdo = (tap_st == T_SHDR) ? dr_sr[0] : (tap_st == T_SHIR) ? ir_sr[0] : 1'b0;

  // tms/tdi must be stable across a whole high phase.
  logic p_tck = 1'b0, p_tms = 1'b0, p_tdi = 1'b0;
  always @(negedge clk) begin
    if (!rst && tck && p_tck && (tms !== p_tms || tdi !== p_tdi)) tms_viol++;
    p_tck = tck; p_tms = tms; p_tdi = tdi;
  end

  // Scoreboard monitor.
  logic        prev_v = 1'b0, prev_hs = 1'b0;
  logic [40:0] held_data = '0;
  logic        held_err = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) chk("rsp_clear", 64'(rsp_valid), 64'd0);
      if (rsp_valid && !prev_v) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, "_err"}, 64'(rsp_err), 64'(e.err));
          chk({e.name, "_data"}, 64'(rsp_data), 64'(e.data));
          chk({e.name, "_latency"}, 64'(cyc - acc_cyc), 64'(e.lat));
          chk({e.name, "_tck_pulses"}, 64'(tck_cnt - acc_tck), 64'(e.pulses));
        end
        held_data = rsp_data;
        held_err  = rsp_err;
      end else if (rsp_valid) begin
        if (rsp_data !== held_data || rsp_err !== held_err) hold_viol++;
      end
      prev_v  = rsp_valid;
      prev_hs = rsp_valid && rsp_ready;
    end
  end

  task automatic send(input string name, input logic [1:0] t, input logic [5:0] l,
                      input logic [40:0] d, input logic e_err, input logic [40:0] e_data,
                      input int e_lat, input int e_pulses, input bit want);
    int n;
    exp_t e;
    e.name = name; e.err = e_err; e.data = e_data; e.lat = e_lat; e.pulses = e_pulses;
    if (want) sb_q.push_back(e);
    @(posedge clk); #1;
    cmd_type = t; cmd_len = l; cmd_data = d; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 2000) begin @(posedge clk); #1; n++; end
    if (n >= 2000) chk({name, "_accept_timeout"}, 64'(n), 64'd0);
    @(posedge clk); #1;
    acc_cyc = cyc;
    acc_tck = tck_cnt;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk({name, "_idle_timeout"}, 64'(n), 64'd0);
  endtask

  task automatic wait_tlr(input string name);
    int rel, t0, n;
    rel = cyc; t0 = tck_cnt; tms_hist = '0;
    @(negedge clk);
    chk({name, "_rst_pins"}, {60'd0, tck, tms, rsp_valid, cmd_ready}, 64'b0100);
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    chk({name, "_ready_cycles"}, 64'(cyc - rel), 64'd24);
    chk({name, "_tlr_pulses"}, 64'(tck_cnt - t0), 64'd6);
    chk({name, "_tlr_tms"}, 64'(tms_hist), 64'b111110);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {15'd0, tck, tms, tdi, cmd_ready, rsp_valid, rsp_err, rsp_data},
        {15'd0, 6'b010000, 41'd0});
    @(posedge clk); #1;
    rst = 1'b0;
    wait_tlr("por");
    chk("por_tap_rti", 64'(tap_st == T_RTI), 64'd1);

    send("ir_dmi", 2'd1, 6'd5, 41'h11, 1'b0, 41'h01, 44, 11, 1'b1);
    wait_idle("ir_dmi");
    chk("tap_ir_dmi", 64'(tap_ir), 64'h11);

    send("ir_idcode", 2'd1, 6'd5, 41'h01, 1'b0, 41'h01, 44, 11, 1'b1);
    send("dr_idcode", 2'd2, 6'd32, 41'h0, 1'b0, 41'h10001001, 148, 37, 1'b1);

    send("ir_dmi2", 2'd1, 6'd5, 41'h11, 1'b0, 41'h01, 44, 11, 1'b1);
    send("dr_dmi_wr", 2'd2, 6'd41, {7'h10, 32'h1, 2'b10}, 1'b0, DMI_CAP, 184, 46, 1'b1);
    wait_idle("dr_dmi_wr");
    chk("dmi_wr_count", 64'(dmi_wr_cnt), 64'd1);
    chk("dmi_addr", 64'(dmi_addr), 64'h10);
    chk("dmi_wdata", 64'(dmi_wdata), 64'h1);

    send("ir_bypass", 2'd1, 6'd5, 41'h1f, 1'b0, 41'h01, 44, 11, 1'b1);
    send("dr_bypass", 2'd2, 6'd8, 41'hA5, 1'b0, 41'h4A, 52, 13, 1'b1);
    wait_idle("dr_bypass");

    rsp_ready = 1'b0;
    send("err_len0", 2'd2, 6'd0, 41'h3, 1'b1, 41'h0, 0, 0, 1'b1);
    n = tck_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk("err_hold_valid", 64'(rsp_valid), 64'd1);
    chk("err_no_tck", 64'(tck_cnt - n), 64'd0);
    rsp_ready = 1'b1;
    send("err_len42", 2'd1, 6'd42, 41'h1, 1'b1, 41'h0, 0, 0, 1'b1);
    send("err_type3", 2'd3, 6'd5, 41'h1, 1'b1, 41'h0, 0, 0, 1'b1);

    send("tap_reset", 2'd0, 6'd7, 41'h5, 1'b0, 41'h0, 24, 6, 1'b1);
    wait_idle("tap_reset");
    chk("tap_reset_rti", 64'(tap_st == T_RTI), 64'd1);

    send("ir_idcode2", 2'd1, 6'd5, 41'h01, 1'b0, 41'h01, 44, 11, 1'b1);
    send("dr_abort", 2'd2, 6'd32, 41'h0, 1'b0, 41'h0, 0, 0, 1'b0);
    n = 0;
    while (tck_cnt < acc_tck + 24 && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) chk("abort_wait_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_tlr("abort");

    send("dr_idcode2", 2'd2, 6'd32, 41'h0, 1'b0, 41'h10001001, 148, 37, 1'b1);
    wait_idle("dr_idcode2");
    repeat (3) @(negedge clk);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    chk("rsp_hold", 64'(hold_viol), 64'd0);
    chk("tms_tdi_stable", 64'(tms_viol), 64'd0);
    chk("dmi_wr_final", 64'(dmi_wr_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/raifes_jtag_master.md
RAIFES_JTAG_MASTER -- requirements
Module: raifes_jtag_master

Interface
REQ-001 Parameter HALF_PERIOD, default 2, SHALL set the number of clk cycles per TCK half-period (legal 1..255).
REQ-002 Parameter MAX_LEN, default 41, SHALL set the maximum scan length in bits (41 = DMI register width).
REQ-003 clk  input  1  Single system clock; all logic on its rising edge.
REQ-004 rst  input  1  Reset, synchronous and active-high.
REQ-005 cmd_valid  input  1  Command request.
REQ-006 cmd_ready  output  1  Master can accept a command.
REQ-007 cmd_type  input  2  Command type: 0 = TAP reset, 1 = IR scan, 2 = DR scan, 3 = illegal.
REQ-008 cmd_len  input  6  Scan length in bits.
REQ-009 cmd_data  input  41  Scan data, LSB shifted first.
REQ-010 rsp_valid  output  1  Response available.
REQ-011 rsp_ready  input  1  Response consumed.
REQ-012 rsp_data  output  41  Captured TDO bits, right-aligned, LSB first captured.
REQ-013 rsp_err  output  1  Command rejected.
REQ-014 tck  output  1  JTAG clock.
REQ-015 tms  output  1  JTAG mode select.
REQ-016 tdi  output  1  JTAG data toward TAP.
REQ-017 tdo  input  1  JTAG data from TAP.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 Each TCK bit SHALL last 2*HALF_PERIOD clk cycles: tck=0 for the first HALF_PERIOD cycles, then tck=1 for the rest.
REQ-020 tms and tdi SHALL change only in the first low-phase cycle of a bit.
REQ-021 tdo SHALL be sampled in the clk cycle in which tck rises from 0 to 1.
REQ-022 The FSM SHALL have the states IDLE, TLR, HDR, SHIFT, TAIL and RESP.
REQ-023 TLR SHALL emit 6 bits with TMS=1,1,1,1,1,0, then go to IDLE, leaving the TAP in Run-Test/Idle.
REQ-024 The IR-scan header SHALL be TMS=1,1,0,0.
REQ-025 The DR-scan header SHALL be TMS=1,0,0.
REQ-026 In headers, tails and TLR, tdi SHALL be 0.
REQ-027 SHIFT SHALL emit cmd_len bits with tdi=cmd_data[i] for i=0..cmd_len-1, TMS=0 on every bit except TMS=1 on the last.
REQ-028 On shift bit i, the sampled tdo SHALL be stored into rsp_data[i].
REQ-029 TAIL SHALL emit TMS=1 then TMS=0, passing through Update and returning to Run-Test/Idle.
REQ-030 cmd_ready SHALL be 1 only in IDLE with rsp_valid=0; a command is accepted when cmd_valid and cmd_ready are both 1.
REQ-031 The command SHALL be latched on acceptance, and the first bit's low phase SHALL begin on the next cycle.
REQ-032 Total scan duration SHALL be (cmd_len+6)*2*HALF_PERIOD clk cycles for an IR scan and (cmd_len+5)*2*HALF_PERIOD for a DR scan.
REQ-033 Scans SHALL set rsp_valid=1 and rsp_err=0 in the cycle after the final high phase; rsp_data bits at cmd_len and above SHALL be 0.
REQ-034 A type-0 command SHALL run TLR, then respond with rsp_data=0 and rsp_err=0.
REQ-035 cmd_len=0, cmd_len>MAX_LEN, or cmd_type=3 SHALL produce no tck edge and set rsp_valid=1, rsp_err=1, rsp_data=0 on the cycle after acceptance.
REQ-036 rsp_valid, rsp_data and rsp_err SHALL hold until rsp_ready=1, then clear next cycle, returning to IDLE.
REQ-037 Between commands, tck SHALL be 0 and tms SHALL be 0.
REQ-038 The bit counter and divider SHALL be sized for MAX_LEN and HALF_PERIOD and SHALL never wrap within a command.

Reset
REQ-039 While rst=1, outputs SHALL be: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0.
REQ-040 While rst=1, the FSM SHALL be held in TLR at bit 0.
REQ-041 After rst deasserts, the master SHALL automatically run the TLR sequence before raising cmd_ready.
REQ-042 rst asserted mid-command SHALL abort that command with no response; outputs take reset values on the next cycle.

Verification (HALF_PERIOD=2, TAP = team DTM)
REQ-043 Release rst -> 6 tck pulses, TMS 1,1,1,1,1,0; cmd_ready=1 exactly 24 cycles later.
REQ-044 IR scan, len 5, data 0x11 -> 11 tck pulses (44 cycles); rsp_data=0x01; DTM IR becomes 0x11.
REQ-045 IR 0x01, then DR scan, len 32 -> rsp_data=0x10001001 (IDCODE).
REQ-046 IR 0x11, then DR scan, len 41, data {7'h10,32'h1,2'b10} -> one-cycle DMI write pulse with dmi_addr=0x10, dmi_wdata=0x1.
REQ-047 cmd_len=0, or cmd_len=42 -> rsp_err=1 one cycle after acceptance; no tck edge; rsp_valid held while rsp_ready=0.
REQ-048 rst pulsed during bit 20 of a DR scan -> next cycle tck=0, tms=1, rsp_valid=0; full TLR sequence follows; no stale response.
